// File: rtl/e_mdu_pkg.sv
// Shared opcode encoding and default latencies for the E-stage multiply/divide unit.
package e_mdu_pkg;

  typedef enum logic [3:0] {
    MduNone  = 4'd0,
    MduMult  = 4'd1,
    MduMultu = 4'd2,
    MduDiv   = 4'd3,
    MduDivu  = 4'd4,
    MduMfhi  = 4'd5,
    MduMflo  = 4'd6,
    MduMthi  = 4'd7,
    MduMtlo  = 4'd8
  } mdu_op_e;

  localparam int unsigned MultCyclesDefault = 5;
  localparam int unsigned DivCyclesDefault  = 10;

  // True for the opcodes that launch a multi-cycle busy countdown.
  function automatic logic is_md_start(input logic [3:0] op);
    return (op == MduMult) || (op == MduMultu) || (op == MduDiv) || (op == MduDivu);
  endfunction

endpackage

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: owns HI/LO, computes results at launch into shadow
// registers and commits them when the busy countdown expires.
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MultCyclesDefault,
  parameter int unsigned DIV_CYCLES  = DivCyclesDefault
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [3:0]  E_MDUOp,
  input  logic        E_start,
  output logic        E_busy,
  output logic [31:0] E_MDOut
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  mdu_op_e op;
  assign op = mdu_op_e'(E_MDUOp);

  logic [CntW-1:0] count_q, count_d;
  logic [31:0]     hi_q, hi_d, lo_q, lo_d;
  logic [31:0]     hi_s_q, hi_s_d, lo_s_q, lo_s_d;
  logic            wr_s_q, wr_s_d;

  logic        a_neg, b_neg, div_zero;
  logic [31:0] a_mag, b_mag, b_mag_safe, b_safe;
  logic [63:0] prod_s, prod_u;
  logic [31:0] qu, ru, qm, rm, qs, rs;

  // Signed division works on magnitudes so 0x80000000 / -1 never overflows a signed divide.
  always_comb begin
    a_neg      = A[31];
    b_neg      = B[31];
    a_mag      = a_neg ? (~A + 32'd1) : A;
    b_mag      = b_neg ? (~B + 32'd1) : B;
    div_zero   = (B == 32'd0);
    b_safe     = div_zero ? 32'd1 : B;
    b_mag_safe = div_zero ? 32'd1 : b_mag;
    prod_s     = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    prod_u     = {32'd0, A} * {32'd0, B};
    qu         = A / b_safe;
    ru         = A % b_safe;
    qm         = a_mag / b_mag_safe;
    rm         = a_mag % b_mag_safe;
    qs         = (a_neg ^ b_neg) ? (~qm + 32'd1) : qm;
    rs         = a_neg ? (~rm + 32'd1) : rm;
  end

  always_comb begin
    count_d = count_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    hi_s_d  = hi_s_q;
    lo_s_d  = lo_s_q;
    wr_s_d  = wr_s_q;
    if (count_q == '0) begin
      if (E_start && is_md_start(E_MDUOp)) begin
        case (op)
          MduMult: begin
            hi_s_d  = prod_s[63:32];
            lo_s_d  = prod_s[31:0];
            wr_s_d  = 1'b1;
            count_d = CntW'(MULT_CYCLES);
          end
          MduMultu: begin
            hi_s_d  = prod_u[63:32];
            lo_s_d  = prod_u[31:0];
            wr_s_d  = 1'b1;
            count_d = CntW'(MULT_CYCLES);
          end
          MduDiv: begin
            hi_s_d  = rs;
            lo_s_d  = qs;
            wr_s_d  = !div_zero;
            count_d = CntW'(DIV_CYCLES);
          end
          default: begin
            hi_s_d  = ru;
            lo_s_d  = qu;
            wr_s_d  = !div_zero;
            count_d = CntW'(DIV_CYCLES);
          end
        endcase
      end else if (op == MduMthi) begin
        hi_d = A;
      end else if (op == MduMtlo) begin
        lo_d = A;
      end
    end else begin
      count_d = count_q - CntW'(1);
      // Commit on the final countdown edge; a divide by zero leaves HI/LO untouched.
      if (count_q == CntW'(1) && wr_s_q) begin
        hi_d = hi_s_q;
        lo_d = lo_s_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      hi_s_q  <= '0;
      lo_s_q  <= '0;
      wr_s_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      hi_s_q  <= hi_s_d;
      lo_s_q  <= lo_s_d;
      wr_s_q  <= wr_s_d;
    end
  end

  assign E_busy = (count_q != '0);

  always_comb begin
    E_MDOut = '0;
    case (op)
      MduMfhi: E_MDOut = hi_q;
      MduMflo: E_MDOut = lo_q;
      default: E_MDOut = '0;
    endcase
  end

endmodule

// File: doc/e_mdu.md
Name: e_mdu

Overview:
- Execute-stage multiply/divide unit.
- Sits beside the E-stage ALU and takes the same forwarded A/B operands.
- Owns the architectural HI/LO registers and models MIPS mult/div latency with a busy countdown.
- Asserts start/busy so the hazard unit stalls D-stage MD instructions.
- Returns HI or LO to the E-stage result mux.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (must be >= 1).
- DIV_CYCLES, 10, busy cycles for div/divu (must be >= 1).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- A  input  32  rs operand, forwarded.
- B  input  32  rt operand, forwarded.
- E_MDUOp  input  4  operation code; encoding in constants.v.
- E_start  input  1  one-cycle pulse; E-stage instruction is mult/multu/div/divu.
- E_busy  output  1  countdown in progress.
- E_MDOut  output  32  HI for MFHI, LO for MFLO, else 0.

Behaviour:
- Reset: HI=0, LO=0, count=0, E_busy=0, shadow regs=0, E_MDOut=0. Reset mid-operation aborts the op; HI/LO are not updated.
- States:
  - IDLE (count==0).
  - RUN (count>0). E_busy = (count != 0).
- IDLE + E_start with op MULT/MULTU/DIV/DIVU, at that edge:
  - compute result into shadow HI_s/LO_s;
  - load count with MULT_CYCLES or DIV_CYCLES.
  - Start at edge T gives E_busy high for the next N cycles.
  - HI/LO are written at the edge where count goes 1→0, and are visible the cycle after busy drops.
- RUN: count decrements each cycle. HI/LO hold their old values until commit.
- MULT: {HI,LO} = signed(A)*signed(B), full 64 bits.
- MULTU: {HI,LO} = A*B, unsigned 64 bits.
- DIV: LO = signed quotient, truncated toward zero; HI = remainder, same sign as dividend. 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- DIVU: LO = A/B, HI = A%B, unsigned.
- Divide by zero (B==0, DIV or DIVU): timing is unchanged (busy for DIV_CYCLES); HI/LO are left unmodified at commit.
- MTHI/MTLO: in IDLE, HI<=A / LO<=A at the edge, single cycle, no busy.
- MTHI/MTLO while busy: ignored; the hazard unit guarantees this never occurs.
- E_start while busy: ignored; the current op is not restarted.
- E_start with a non-mult/div op: ignored.
- MFHI/MFLO: combinational read of the committed HI/LO. Values are stale while busy; the hazard unit must stall.
- E_MDOut: combinational from E_MDUOp and HI/LO.
- No flush input. Once started, an op always completes.
- Stall contract: stall D if (E_start | E_busy) and the D instruction is any MD op.

Decomposition:
- constants.v additions:
  - MDU_NONE=0, MDU_MULT=1, MDU_MULTU=2, MDU_DIV=3, MDU_DIVU=4, MDU_MFHI=5, MDU_MFLO=6, MDU_MTHI=7, MDU_MTLO=8;
  - default MULT_CYCLES/DIV_CYCLES values.
- No sub-module. Arithmetic is behavioural (* / %) inside e_mdu. The countdown is a small always block.

Test Plan:
1. MULT A=0xFFFFFFFE (-2), B=3, start at T → E_busy high T+1..T+5; at T+6 MFHI=0xFFFFFFFF, MFLO=0xFFFFFFFA.
2. MULTU, same operands → HI=0x00000002, LO=0xFFFFFFFA; MFLO during busy still returns the old LO.
3. DIV A=-7 (0xFFFFFFF9), B=2 → busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/0 → busy 10 cycles; HI/LO unchanged.
4. MTHI A=0x12345678 in IDLE, then MFHI next cycle → 0x12345678, E_busy stays 0. Second E_start (MULT 2*2) during a DIV → ignored; DIV result committed.
5. MULT started, reset asserted at busy cycle 3 → next cycle E_busy=0, HI=LO=0; a later MULT 3*4 → LO=12, HI=0.
6. DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0, no X.
